gate_sweep_capture: RTL

GATE_SWEEP_CAPTURE -- requirements
Module: gate_sweep_capture

---
 rtl/gate_sweep_capture_pkg.sv | 41 ++++
 rtl/gate_sweep_capture_if.sv | 26 ++
 rtl/gate_sweep_capture_timer.sv | 34 +++
 rtl/gate_sweep_capture.sv | 136 +++++++++++++
 4 files changed

// File: rtl/gate_sweep_capture_pkg.sv
// Shared types and constants for the gate truth-table sweep block.
// Golden vectors are indexed by the stimulus index idx = {a, b}.
package gate_sweep_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int FIELD_W = 7;
    localparam int N_VEC   = 4;
    localparam int TABLE_W = FIELD_W * N_VEC;
    localparam int CNT_W   = 8;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOTA = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;

    localparam logic [FIELD_W-1:0] GOLDEN_V0 = 7'h5C;
    localparam logic [FIELD_W-1:0] GOLDEN_V1 = 7'h2E;
    localparam logic [FIELD_W-1:0] GOLDEN_V2 = 7'h2A;
    localparam logic [FIELD_W-1:0] GOLDEN_V3 = 7'h43;

    function automatic logic [FIELD_W-1:0] golden_vec(input logic [1:0] idx);
        logic [FIELD_W-1:0] v;
        case (idx)
            2'd0:    v = GOLDEN_V0;
            2'd1:    v = GOLDEN_V1;
            2'd2:    v = GOLDEN_V2;
            default: v = GOLDEN_V3;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/gate_sweep_capture_if.sv
// Signal bundle between the sweep controller (slave) and the gate stage /
// result consumer (master).
interface gate_sweep_capture_if;
    import gate_sweep_capture_pkg::*;

    logic                 start;
    logic                 a_out;
    logic                 b_out;
    logic [FIELD_W-1:0]   gate_in;
    logic [TABLE_W-1:0]   table_out;
    logic [FIELD_W-1:0]   mismatch;
    logic                 busy;
    logic                 done_valid;
    logic                 done_ready;

    modport master (
        output start, gate_in, done_ready,
        input  a_out, b_out, table_out, mismatch, busy, done_valid
    );

    modport slave (
        input  start, gate_in, done_ready,
        output a_out, b_out, table_out, mismatch, busy, done_valid
    );

endinterface

// File: rtl/gate_sweep_capture_timer.sv
// Settle down-counter: load takes priority, otherwise counts down to 0 and
// stops; expired flags the last settle cycle (count == 1).
module sweep_settle_timer
    import gate_sweep_capture_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/gate_sweep_capture.sv
// Drives all four {a,b} vectors into a logic-gate stage and captures its
// 7 outputs per vector. Per-gate golden checking is built only when
// GATE_SWEEP_CHECK_EN is defined; otherwise mismatch is tied to 0.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  ST_IDLE   | waiting for start, a/b held at 0
//  ST_SETTLE | a/b applied, waiting SETTLE_CYCLES for the stage
//  ST_SAMPLE | capture gate_in into field idx
//  ST_DONE   | result valid, waiting for done_ready
module gate_sweep_capture
    import gate_sweep_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_sweep_capture_if.slave  bus
);

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic [TABLE_W-1:0] tab_q, tab_d;
    logic               tmr_load;
    logic               tmr_expired;
    logic [1:0]         idx_nxt;

`ifdef GATE_SWEEP_CHECK_EN
    logic [FIELD_W-1:0] mis_q, mis_d;
`endif

    sweep_settle_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (CNT_W'(SETTLE_CYCLES)),
        .expired (tmr_expired)
    );

    assign idx_nxt = idx_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        tab_d    = tab_q;
        tmr_load = 1'b0;
`ifdef GATE_SWEEP_CHECK_EN
        mis_d    = mis_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    tab_d    = '0;
`ifdef GATE_SWEEP_CHECK_EN
                    mis_d    = '0;
`endif
                    idx_d    = 2'd0;
                    a_d      = 1'b0;
                    b_d      = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                tab_d[idx_q*FIELD_W +: FIELD_W] = bus.gate_in;
`ifdef GATE_SWEEP_CHECK_EN
                mis_d = mis_q | (bus.gate_in ^ golden_vec(idx_q));
`endif
                if (idx_q == 2'd3) begin
                    // a/b return to 0 so the stage sees a quiet input while results wait
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d    = idx_nxt;
                    a_d      = idx_nxt[1];
                    b_d      = idx_nxt[0];
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (bus.done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            tab_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tab_q   <= tab_d;
        end
    end

`ifdef GATE_SWEEP_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= '0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign bus.mismatch = mis_q;
`else
    assign bus.mismatch = '0;
`endif

    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.table_out  = tab_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done_valid = (state_q == ST_DONE);

endmodule
